// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage_if
// Brief    : Decode-side bundle into the ID/EX stage and the launched EX-side
//            bundle out of it, plus the upstream stall request.
// Revision : 1.0 - initial release
// ============================================================================
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CTRL_W = 8
);
  // decode side
  logic              in_valid;
  logic [ADDR_W-1:0] in_rs;
  logic [ADDR_W-1:0] in_rt;
  logic [ADDR_W-1:0] in_rd;
  logic [DATA_W-1:0] in_imm;
  logic [CTRL_W-1:0] in_ctrl;
  logic              stall_req;

  // execute side
  logic              ex_valid;
  logic [ADDR_W-1:0] ex_rs;
  logic [ADDR_W-1:0] ex_rt;
  logic [ADDR_W-1:0] ex_rd;
  logic [DATA_W-1:0] ex_op1;
  logic [DATA_W-1:0] ex_op2;
  logic [DATA_W-1:0] ex_imm;
  logic [CTRL_W-1:0] ex_ctrl;

  // environment (decoder + execute consumer)
  modport master (
    output in_valid, in_rs, in_rt, in_rd, in_imm, in_ctrl,
    input  stall_req,
    input  ex_valid, ex_rs, ex_rt, ex_rd, ex_op1, ex_op2, ex_imm, ex_ctrl
  );

  // the pipeline stage itself
  modport slave (
    input  in_valid, in_rs, in_rt, in_rd, in_imm, in_ctrl,
    output stall_req,
    output ex_valid, ex_rs, ex_rt, ex_rd, ex_op1, ex_op2, ex_imm, ex_ctrl
  );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Brief    : Decode-to-execute stage behind a registered-read register file.
//            Slot A holds the decoded fields while the regfile read is in
//            flight; slot B (ex_*) launches them with the returned operands,
//            repairing same-edge write-back collisions through a one-entry
//            bypass register. Detects load-use hazards and stalls upstream.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CTRL_W = 8
) (
  input  wire logic              clk,
  input  wire logic              rst,
  id_ex_stage_if.slave           bus,
  input  wire logic [DATA_W-1:0] rf_data1,
  input  wire logic [DATA_W-1:0] rf_data2,
  input  wire logic              wb_en,
  input  wire logic [ADDR_W-1:0] wb_reg,
  input  wire logic [DATA_W-1:0] wb_data,
  input  wire logic              flush
);

  localparam logic [ADDR_W-1:0] c_zero_reg     = '0;
  localparam int                c_mem_read_bit = 0;

  // slot A: instruction whose register read is in flight
  logic              a_valid_q, a_valid_d;
  logic [ADDR_W-1:0] a_rs_q,    a_rs_d;
  logic [ADDR_W-1:0] a_rt_q,    a_rt_d;
  logic [ADDR_W-1:0] a_rd_q,    a_rd_d;
  logic [DATA_W-1:0] a_imm_q,   a_imm_d;
  logic [CTRL_W-1:0] a_ctrl_q,  a_ctrl_d;

  // bypass: the write-back that shared an edge with the regfile read
  logic              bp_en_q,   bp_en_d;
  logic [ADDR_W-1:0] bp_reg_q,  bp_reg_d;
  logic [DATA_W-1:0] bp_data_q, bp_data_d;

  // slot B: launched to EX
  logic              ex_valid_q, ex_valid_d;
  logic [ADDR_W-1:0] ex_rs_q,    ex_rs_d;
  logic [ADDR_W-1:0] ex_rt_q,    ex_rt_d;
  logic [ADDR_W-1:0] ex_rd_q,    ex_rd_d;
  logic [DATA_W-1:0] ex_op1_q,   ex_op1_d;
  logic [DATA_W-1:0] ex_op2_q,   ex_op2_d;
  logic [DATA_W-1:0] ex_imm_q,   ex_imm_d;
  logic [CTRL_W-1:0] ex_ctrl_q,  ex_ctrl_d;

  logic stall_req;

  // Register 0 is hard zero; otherwise the bypassed write wins over the
  // regfile, which returned the value from before that write landed.
  function automatic logic [DATA_W-1:0] pick_operand(
    input logic [ADDR_W-1:0] idx,
    input logic [DATA_W-1:0] rf_val,
    input logic              bp_en,
    input logic [ADDR_W-1:0] bp_reg,
    input logic [DATA_W-1:0] bp_data
  );
    logic [DATA_W-1:0] val;
    if (idx == c_zero_reg) begin
      val = '0;
    end else if (bp_en && (bp_reg == idx)) begin
      val = bp_data;
    end else begin
      val = rf_val;
    end
    return val;
  endfunction

  // Load-use hazard: the load in EX writes a register the waiting instruction reads.
  always_comb begin
    stall_req = ex_valid_q && ex_ctrl_q[c_mem_read_bit] && (ex_rt_q != c_zero_reg) &&
                a_valid_q && ((a_rs_q == ex_rt_q) || (a_rt_q == ex_rt_q));
  end

  // Slot A captures a new instruction unless stalled; flush kills it regardless.
  always_comb begin
    a_valid_d = a_valid_q;
    a_rs_d    = a_rs_q;
    a_rt_d    = a_rt_q;
    a_rd_d    = a_rd_q;
    a_imm_d   = a_imm_q;
    a_ctrl_d  = a_ctrl_q;
    if (!stall_req) begin
      a_valid_d = bus.in_valid;
      a_rs_d    = bus.in_rs;
      a_rt_d    = bus.in_rt;
      a_rd_d    = bus.in_rd;
      a_imm_d   = bus.in_imm;
      a_ctrl_d  = bus.in_ctrl;
    end
    if (flush) begin
      a_valid_d = 1'b0;
    end
  end

  // Remember every edge's write-back; writes to register 0 never count.
  always_comb begin
    bp_en_d   = wb_en && (wb_reg != c_zero_reg);
    bp_reg_d  = wb_reg;
    bp_data_d = wb_data;
  end

  // Slot B launches slot A with aligned operands; a stall or flush inserts a bubble.
  always_comb begin
    ex_valid_d = a_valid_q && !stall_req && !flush;
    ex_rs_d    = a_rs_q;
    ex_rt_d    = a_rt_q;
    ex_rd_d    = a_rd_q;
    ex_imm_d   = a_imm_q;
    ex_ctrl_d  = a_ctrl_q;
    ex_op1_d   = pick_operand(a_rs_q, rf_data1, bp_en_q, bp_reg_q, bp_data_q);
    ex_op2_d   = pick_operand(a_rt_q, rf_data2, bp_en_q, bp_reg_q, bp_data_q);
  end

  // State registers; reset discards any in-flight instruction at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid_q  <= 1'b0;
      a_rs_q     <= '0;
      a_rt_q     <= '0;
      a_rd_q     <= '0;
      a_imm_q    <= '0;
      a_ctrl_q   <= '0;
      bp_en_q    <= 1'b0;
      bp_reg_q   <= '0;
      bp_data_q  <= '0;
      ex_valid_q <= 1'b0;
      ex_rs_q    <= '0;
      ex_rt_q    <= '0;
      ex_rd_q    <= '0;
      ex_op1_q   <= '0;
      ex_op2_q   <= '0;
      ex_imm_q   <= '0;
      ex_ctrl_q  <= '0;
    end else begin
      a_valid_q  <= a_valid_d;
      a_rs_q     <= a_rs_d;
      a_rt_q     <= a_rt_d;
      a_rd_q     <= a_rd_d;
      a_imm_q    <= a_imm_d;
      a_ctrl_q   <= a_ctrl_d;
      bp_en_q    <= bp_en_d;
      bp_reg_q   <= bp_reg_d;
      bp_data_q  <= bp_data_d;
      ex_valid_q <= ex_valid_d;
      ex_rs_q    <= ex_rs_d;
      ex_rt_q    <= ex_rt_d;
      ex_rd_q    <= ex_rd_d;
      ex_op1_q   <= ex_op1_d;
      ex_op2_q   <= ex_op2_d;
      ex_imm_q   <= ex_imm_d;
      ex_ctrl_q  <= ex_ctrl_d;
    end
  end

  assign bus.stall_req = stall_req;
  assign bus.ex_valid  = ex_valid_q;
  assign bus.ex_rs     = ex_rs_q;
  assign bus.ex_rt     = ex_rt_q;
  assign bus.ex_rd     = ex_rd_q;
  assign bus.ex_op1    = ex_op1_q;
  assign bus.ex_op2    = ex_op2_q;
  assign bus.ex_imm    = ex_imm_q;
  assign bus.ex_ctrl   = ex_ctrl_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage
// Brief    : Self-checking bench for id_ex_stage. A behavioural register file
//            with registered, read-before-write reads feeds the stage. A
//            transaction-level model predicts each launch from the
//            architectural register contents; a negedge monitor compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] rf_data1 = '0;
  logic [DW-1:0] rf_data2 = '0;
  logic          wb_en;
  logic [AW-1:0] wb_reg;
  logic [DW-1:0] wb_data;
  logic          flush;

  always #5 clk = ~clk;

  id_ex_stage_if #(.DATA_W(DW), .ADDR_W(AW), .CTRL_W(CW)) bus ();

  id_ex_stage #(.DATA_W(DW), .ADDR_W(AW), .CTRL_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .rf_data1 (rf_data1),
    .rf_data2 (rf_data2),
    .wb_en    (wb_en),
    .wb_reg   (wb_reg),
    .wb_data  (wb_data),
    .flush    (flush)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // register file: registered reads return the value from before a same-edge write
  logic [DW-1:0] arch [32] = '{default: '0};
  always @(posedge clk) begin
    rf_data1 <= arch[bus.in_rs];
    rf_data2 <= arch[bus.in_rt];
    if (wb_en && (wb_reg != '0)) arch[wb_reg] <= wb_data;
  end

  // reference model: one waiting instruction and the load status of the one in EX
  typedef struct packed {
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [AW-1:0] rd;
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
    logic [DW-1:0] imm;
    logic [CW-1:0] ctrl;
  } exp_t;

  exp_t          q[$];
  logic          m_a_valid = 1'b0;
  logic [AW-1:0] m_a_rs = '0, m_a_rt = '0, m_a_rd = '0;
  logic [DW-1:0] m_a_imm = '0;
  logic [CW-1:0] m_a_ctrl = '0;
  logic          m_ex_valid = 1'b0;
  logic          m_ex_load = 1'b0;
  logic [AW-1:0] m_ex_rt = '0;
  logic          m_hz;
  exp_t          m_new;

  // waiting instruction needs a register a load in EX has not yet produced
  function automatic logic model_stall();
    return m_ex_valid && m_ex_load && (m_ex_rt != '0) && m_a_valid &&
           ((m_a_rs == m_ex_rt) || (m_a_rt == m_ex_rt));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_a_valid  = 1'b0;
      m_ex_valid = 1'b0;
      m_ex_load  = 1'b0;
      m_ex_rt    = '0;
      q.delete();
    end else begin
      m_hz = model_stall();
      if (m_a_valid && !m_hz && !flush) begin
        m_new.rs   = m_a_rs;
        m_new.rt   = m_a_rt;
        m_new.rd   = m_a_rd;
        m_new.imm  = m_a_imm;
        m_new.ctrl = m_a_ctrl;
        // operands are the architectural values as of all writes before this edge
        m_new.op1  = (m_a_rs == '0) ? '0 : arch[m_a_rs];
        m_new.op2  = (m_a_rt == '0) ? '0 : arch[m_a_rt];
        q.push_back(m_new);
        m_ex_valid = 1'b1;
        m_ex_load  = m_a_ctrl[0];
        m_ex_rt    = m_a_rt;
      end else begin
        m_ex_valid = 1'b0;
      end
      if (!m_hz) begin
        m_a_valid = bus.in_valid;
        m_a_rs    = bus.in_rs;
        m_a_rt    = bus.in_rt;
        m_a_rd    = bus.in_rd;
        m_a_imm   = bus.in_imm;
        m_a_ctrl  = bus.in_ctrl;
      end
      if (flush) m_a_valid = 1'b0;
    end
  end

  // monitor
  exp_t mon_act;
  exp_t mon_exp;
  always @(negedge clk) begin
    if (!rst) begin
      check("stall_req", 128'(bus.stall_req), 128'(model_stall()));
      if (bus.ex_valid) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_launch: got ex_valid=1 rd=%0d, expected no launch", bus.ex_rd);
        end else begin
          mon_exp      = q.pop_front();
          mon_act.rs   = bus.ex_rs;
          mon_act.rt   = bus.ex_rt;
          mon_act.rd   = bus.ex_rd;
          mon_act.op1  = bus.ex_op1;
          mon_act.op2  = bus.ex_op2;
          mon_act.imm  = bus.ex_imm;
          mon_act.ctrl = bus.ex_ctrl;
          check("launch", 128'(mon_act), 128'(mon_exp));
        end
      end else if (q.size() != 0) begin
        n_vec++;
        n_err++;
        $display("FAIL missing_launch: got ex_valid=0, expected launch of rd=%0d", q[0].rd);
        q.delete();
      end
    end
  end

  // driver helpers
  task automatic step();
    @(posedge clk);
    #1;
    wb_en = 1'b0;
    flush = 1'b0;
  endtask

  task automatic write_back(input logic [AW-1:0] r, input logic [DW-1:0] d);
    wb_en   = 1'b1;
    wb_reg  = r;
    wb_data = d;
    step();
  endtask

  task automatic issue(input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic [AW-1:0] rd,
                       input logic [DW-1:0] imm, input logic [CW-1:0] ctrl);
    int   guard;
    logic st;
    guard        = 0;
    bus.in_valid = 1'b1;
    bus.in_rs    = rs;
    bus.in_rt    = rt;
    bus.in_rd    = rd;
    bus.in_imm   = imm;
    bus.in_ctrl  = ctrl;
    do begin
      st = bus.stall_req;
      step();
      guard++;
    end while (st && guard < 20);
    if (st) begin
      n_vec++;
      n_err++;
      $display("FAIL issue_timeout: got stall_req=1 after %0d cycles, expected acceptance", guard);
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    wb_en        = 1'b0;
    wb_reg       = '0;
    wb_data      = '0;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_rs    = '0;
    bus.in_rt    = '0;
    bus.in_rd    = '0;
    bus.in_imm   = '0;
    bus.in_ctrl  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ex_valid", 128'(bus.ex_valid), 128'(0));
    check("reset_stall",    128'(bus.stall_req), 128'(0));
    check("reset_ex_ops",   128'({bus.ex_op1, bus.ex_op2}), 128'(0));
    check("reset_ex_fields", 128'({bus.ex_rs, bus.ex_rt, bus.ex_rd, bus.ex_imm, bus.ex_ctrl}), 128'(0));
    rst = 1'b0;

    // plain launch: and $t1,$t2,$t3 with t2=3, t3=4
    write_back(5'd10, 32'd3);
    write_back(5'd11, 32'd4);
    issue(5'd10, 5'd11, 5'd9, 32'd0, 8'h02);
    check("latency_one_cycle", 128'(bus.ex_valid), 128'(0));
    step();
    check("plain_valid", 128'(bus.ex_valid), 128'(1));
    check("plain_ops",   128'({bus.ex_op1, bus.ex_op2}), 128'({32'd3, 32'd4}));
    check("plain_rd",    128'(bus.ex_rd), 128'(9));

    // write-back to r10 on the very edge that samples rs=10
    wb_en = 1'b1; wb_reg = 5'd10; wb_data = 32'd50;
    issue(5'd10, 5'd11, 5'd12, 32'd0, 8'h00);
    step();
    check("collision_op1", 128'(bus.ex_op1), 128'(50));

    // write-back to r0 must never reach an operand
    wb_en = 1'b1; wb_reg = 5'd0; wb_data = 32'd77;
    issue(5'd0, 5'd11, 5'd13, 32'd0, 8'h00);
    step();
    check("zero_reg_op1", 128'(bus.ex_op1), 128'(0));

    // load-use: lw $t1 then a reader of $t1
    issue(5'd10, 5'd9, 5'd0, 32'd4, 8'h01);
    issue(5'd9, 5'd11, 5'd14, 32'd0, 8'h00);
    check("loaduse_stall", 128'(bus.stall_req), 128'(1));
    wb_en = 1'b1; wb_reg = 5'd9; wb_data = 32'h1234;
    step();
    check("loaduse_bubble", 128'({bus.stall_req, bus.ex_valid}), 128'(0));
    step();
    check("loaduse_release", 128'({bus.ex_valid, bus.ex_op1}), 128'({1'b1, 32'h1234}));

    // flush while stalled
    issue(5'd10, 5'd9, 5'd0, 32'd8, 8'h01);
    issue(5'd9, 5'd9, 5'd15, 32'd0, 8'h00);
    check("flush_pre_stall", 128'(bus.stall_req), 128'(1));
    flush = 1'b1;
    step();
    check("flush_kill", 128'({bus.stall_req, bus.ex_valid}), 128'(0));
    step();
    check("flush_no_launch", 128'(bus.ex_valid), 128'(0));

    // reset with both slots occupied
    issue(5'd1, 5'd2, 5'd3, 32'd5, 8'h00);
    issue(5'd4, 5'd5, 5'd6, 32'd6, 8'h00);
    check("pre_reset_valid", 128'(bus.ex_valid), 128'(1));
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", 128'({bus.ex_valid, bus.stall_req}), 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    step();
    check("post_reset_no_launch", 128'(bus.ex_valid), 128'(0));

    // randomized traffic over a small register window to provoke hazards
    for (int c = 0; c < 3000; c++) begin
      if (!bus.stall_req) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.in_rs    = AW'($urandom_range(0, 7));
        bus.in_rt    = AW'($urandom_range(0, 7));
        bus.in_rd    = AW'($urandom_range(0, 31));
        bus.in_imm   = $urandom;
        bus.in_ctrl  = CW'($urandom);
      end
      wb_en   = ($urandom_range(0, 1) == 1);
      wb_reg  = AW'($urandom_range(0, 7));
      wb_data = $urandom;
      flush   = ($urandom_range(0, 15) == 0);
      @(posedge clk);
      #1;
    end
    wb_en        = 1'b0;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    repeat (6) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
